// File: rtl/ppi_pkg.sv
// Shared types and constants for the ppi Port A Mode 2 peripheral agent.
// States, grant tracking, default handshake timing and PC pin indices.
package ppi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STB_LO,
    HOLD,
    WAIT_IBF,
    ACK_LO,
    WAIT_OBF
  } state_t;

  typedef enum logic {
    TX,
    ACK
  } grant_t;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STB_WIDTH  = 2;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_ACK_WIDTH  = 2;
  localparam int DEF_HS_TIMEOUT = 16;

  localparam int PC_STB = 4;
  localparam int PC_IBF = 5;
  localparam int PC_ACK = 6;
  localparam int PC_OBF = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ppi_sync2.sv
// Two-flop synchronizer for the asynchronous PC handshake inputs.
// RST_VAL is the idle level of the pin so reset never fakes an event.
module ppi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ppi_porta_peripheral.sv
// Peripheral-side agent for ppi Port A Mode 2: strobes bytes in with STBb
// and acknowledges outbound bytes with ACKb, alternating when both pend.
module ppi_porta_peripheral
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STB_WIDTH  = DEF_STB_WIDTH,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int ACK_WIDTH  = DEF_ACK_WIDTH,
  parameter int HS_TIMEOUT = DEF_HS_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic       pa_oe,
  output logic       stbb,
  output logic       ackb,
  input  logic       ibf,
  input  logic       obfb,
  output logic       hs_err
);

  localparam int MAX_P = max2(max2(max2(SETUP_CYC, STB_WIDTH),
                                   max2(HOLD_CYC, ACK_WIDTH)),
                              HS_TIMEOUT);
  localparam int CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_STB   = CW'(STB_WIDTH - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_ACK   = CW'(ACK_WIDTH - 1);
  localparam logic [CW-1:0] LD_TMO   = CW'(HS_TIMEOUT - 1);

  state_t        state;
  grant_t        grant_last;
  logic [CW-1:0] cnt;
  logic          ibf_s;
  logic          obfb_s;
  logic          obf_s;
  logic          ack_elig;
  logic          pick_ack;
  logic          cnt_done;

  ppi_sync2 #(.RST_VAL(1'b0)) u_sync_ibf (
    .clk   (clk),
    .reset (reset),
    .d     (ibf),
    .q     (ibf_s)
  );

  ppi_sync2 #(.RST_VAL(1'b1)) u_sync_obf (
    .clk   (clk),
    .reset (reset),
    .d     (obfb),
    .q     (obfb_s)
  );

  assign obf_s    = !obfb_s;
  assign ack_elig = obf_s && !rx_valid;
  assign pick_ack = ack_elig && (grant_last == TX || !tx_valid);
  assign tx_ready = (state == IDLE) && !ibf_s && !pick_ack;
  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_last <= TX;
      cnt        <= '0;
      stbb       <= 1'b1;
      ackb       <= 1'b1;
      pa_oe      <= 1'b0;
      pa_out     <= 8'h00;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      hs_err     <= 1'b0;
    end else begin
      hs_err <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_ack) begin
            ackb       <= 1'b0;
            grant_last <= ACK;
            cnt        <= LD_ACK;
            state      <= ACK_LO;
          end else if (tx_valid && tx_ready) begin
            pa_out     <= tx_data;
            pa_oe      <= 1'b1;
            grant_last <= TX;
            cnt        <= LD_SETUP;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            stbb  <= 1'b0;
            cnt   <= LD_STB;
            state <= STB_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STB_LO: begin
          if (cnt_done) begin
            stbb  <= 1'b1;
            cnt   <= LD_HOLD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_done) begin
            pa_oe <= 1'b0;
            cnt   <= LD_TMO;
            state <= WAIT_IBF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_IBF: begin
          if (ibf_s) begin
            state <= IDLE;
          end else if (cnt_done) begin
            hs_err <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Port A is sampled on the final low cycle of ACKb.
        ACK_LO: begin
          if (cnt_done) begin
            rx_data  <= pa_in;
            rx_valid <= 1'b1;
            ackb     <= 1'b1;
            cnt      <= LD_TMO;
            state    <= WAIT_OBF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Wait out synchronizer lag so one OBFb assertion gets one ACK.
        WAIT_OBF: begin
          if (!obf_s) begin
            state <= IDLE;
          end else if (cnt_done) begin
            hs_err <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_porta_peripheral.sv
// Directed bench for ppi_porta_peripheral with a hand-driven ppi model.
// Outputs are sampled 1ns after the rising edge.
module tb_ppi_porta_peripheral;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] pa_in;
  logic [7:0] pa_out;
  logic       pa_oe;
  logic       stbb;
  logic       ackb;
  logic       ibf;
  logic       obfb;
  logic       hs_err;

  int checks;
  int failures;
  int n;
  int c_oe;
  int c_stb;
  int c_ack;
  int c_hs;
  int c_rdy;
  int first_stb;

  ppi_porta_peripheral dut (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .pa_in    (pa_in),
    .pa_out   (pa_out),
    .pa_oe    (pa_oe),
    .stbb     (stbb),
    .ackb     (ackb),
    .ibf      (ibf),
    .obfb     (obfb),
    .hs_err   (hs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("inv_oe_ack", {31'd0, pa_oe && !ackb}, 32'd0);
      check("inv_stb_ack", {31'd0, !stbb && !ackb}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    pa_in    = 8'h00;
    ibf      = 1'b0;
    obfb     = 1'b1;
    step();
    step();
    step();
    reset = 1'b0;

    check("rst_stbb", stbb, 1);
    check("rst_ackb", ackb, 1);
    check("rst_pa_oe", pa_oe, 0);
    check("rst_pa_out", pa_out, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_hs_err", hs_err, 0);

    // tx of A5, model ppi raises ibf two cycles after stbb rises
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    check("tx_ready_idle", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    c_oe = 0; c_stb = 0; c_hs = 0; first_stb = 0;
    for (int i = 1; i <= 12; i++) begin
      if (pa_oe) begin
        c_oe++;
        check("tx_pa_out", pa_out, 8'hA5);
      end
      if (!stbb) begin
        c_stb++;
        if (first_stb == 0) first_stb = i;
      end
      if (hs_err) c_hs++;
      if (i == 6) ibf = 1'b1;
      step();
    end
    check("tx_oe_cycles", c_oe, 4);
    check("tx_stb_cycles", c_stb, 2);
    check("tx_stb_start", first_stb, 2);
    check("tx_no_hs_err", c_hs, 0);
    check("tx_blocked_ibf", tx_ready, 0);
    ibf = 1'b0;
    step();
    step();
    check("tx_ready_after_read", tx_ready, 1);

    // ppi drops obfb with AA on Port A
    obfb  = 1'b0;
    pa_in = 8'hAA;
    c_ack = 0; c_oe = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ackb) c_ack++;
      if (pa_oe) c_oe++;
      step();
    end
    check("rx_ack_cycles", c_ack, 2);
    check("rx_oe_quiet", c_oe, 0);
    check("rx_valid_set", rx_valid, 1);
    check("rx_data_aa", rx_data, 8'hAA);
    check("rx_wait_obf_busy", tx_ready, 0);
    obfb = 1'b1;
    step();
    step();
    step();
    check("rx_back_idle", tx_ready, 1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("rx_consumed", rx_valid, 0);

    // both pending after reset: ACK first
    reset = 1'b1;
    obfb  = 1'b0;
    pa_in = 8'h5A;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    tx_valid = 1'b1;
    tx_data  = 8'h35;
    check("arb_ack_first_rdy", tx_ready, 0);
    step();
    check("arb_ack_first", ackb, 0);
    step();
    step();
    check("arb_ack_rx_valid", rx_valid, 1);
    check("arb_ack_rx_data", rx_data, 8'h5A);
    obfb     = 1'b1;
    rx_ready = 1'b1;
    ibf      = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
    step();
    obfb = 1'b0;
    step();
    step();
    step();
    // both pending again with grant on ACK, tx held off by ibf
    c_ack = 0; c_oe = 0;
    for (int i = 0; i < 4; i++) begin
      if (!ackb) c_ack++;
      if (pa_oe) c_oe++;
      step();
    end
    check("arb_no_ack_second", c_ack, 0);
    check("arb_no_tx_ibf", c_oe, 0);
    ibf = 1'b0;
    n = 0;
    while (pa_oe !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("arb_tx_second_seen", {31'd0, n < 20}, 1);
    check("arb_tx_second_data", pa_out, 8'h35);
    check("arb_tx_second_ackb", ackb, 1);
    tx_valid = 1'b0;
    pa_in    = 8'hC3;
    step();
    step();
    step();
    step();
    step();
    ibf = 1'b1;
    n = 0;
    while (ackb !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check("arb_ack_after_tx", {31'd0, n < 20}, 1);
    step();
    step();
    check("arb_ack2_rx_valid", rx_valid, 1);
    check("arb_ack2_rx_data", rx_data, 8'hC3);

    // held rx byte blocks further ACKs until consumed
    obfb = 1'b1;
    ibf  = 1'b0;
    step();
    step();
    step();
    obfb = 1'b0;
    c_ack = 0;
    for (int i = 0; i < 6; i++) begin
      if (!ackb) c_ack++;
      step();
    end
    check("rx_full_no_ack", c_ack, 0);
    check("rx_full_held", rx_valid, 1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
    check("ack_resume", ackb, 0);
    step();
    step();
    obfb     = 1'b1;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
    step();
    step();

    // ibf never rises: timeout after 16 cycles in WAIT_IBF
    reset = 1'b1;
    step();
    step();
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    check("tmo_tx_ready", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    c_hs = 0;
    for (int i = 1; i <= 20; i++) begin
      if (hs_err) c_hs++;
      step();
    end
    check("tmo_no_early_err", c_hs, 0);
    check("tmo_hs_err", hs_err, 1);
    step();
    check("tmo_hs_err_pulse", hs_err, 0);
    check("tmo_idle", tx_ready, 1);

    ibf = 1'b1;
    step();
    step();
    tx_valid = 1'b1;
    c_rdy = 0; c_oe = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_ready) c_rdy++;
      if (pa_oe) c_oe++;
      step();
    end
    check("ibf_high_no_ready", c_rdy, 0);
    check("ibf_high_no_oe", c_oe, 0);
    tx_valid = 1'b0;
    ibf      = 1'b0;
    step();
    step();

    // reset during STB_LO
    tx_valid = 1'b1;
    tx_data  = 8'h0F;
    step();
    tx_valid = 1'b0;
    step();
    check("rst_stb_reached", stbb, 0);
    reset = 1'b1;
    step();
    check("rst_stb_stbb", stbb, 1);
    check("rst_stb_ackb", ackb, 1);
    check("rst_stb_oe", pa_oe, 0);
    check("rst_stb_rxv", rx_valid, 0);
    reset = 1'b0;

    // reset during ACK_LO
    obfb  = 1'b0;
    pa_in = 8'h77;
    n = 0;
    while (ackb !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check("rst_ack_reached", {31'd0, n < 20}, 1);
    reset = 1'b1;
    step();
    check("rst_ack_ackb", ackb, 1);
    check("rst_ack_stbb", stbb, 1);
    check("rst_ack_oe", pa_oe, 0);
    check("rst_ack_rxv", rx_valid, 0);
    check("rst_ack_rxd", rx_data, 8'h00);
    obfb = 1'b1;
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppi_porta_peripheral.md
Name: ppi_porta_peripheral

Overview:
- Peripheral-side agent for the ppi block's Port A in Mode 2 (strobed bidirectional), with PC4 = STBb, PC5 = IBF, PC6 = ACKb and PC7 = OBFb.
- Inbound to ppi: accepts bytes on a valid/ready interface, drives them onto Port A and pulses STBb.
- Outbound from ppi: watches OBFb, pulses ACKb, samples the byte the ppi drives on Port A, and presents it on a valid/ready interface.
- Sits between the ppi pins and a device-side byte source/sink. It forms the other end of the Mode 2 handshake.

Parameters:
- SETUP_CYC, 1: cycles Port A is driven before STBb falls (min 1).
- STB_WIDTH, 2: cycles STBb is held low (min 1).
- HOLD_CYC, 1: cycles Port A stays driven after STBb rises (min 1).
- ACK_WIDTH, 2: cycles ACKb is held low; Port A is sampled on the last low cycle (min 2).
- HS_TIMEOUT, 16: cycles allowed for the IBF/OBFb response before an error is flagged.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  device has a byte for ppi
- tx_data  in  8  byte to send
- tx_ready  out  1  byte accepted this cycle when tx_valid=1
- rx_valid  out  1  byte from ppi is held
- rx_data  out  8  held byte
- rx_ready  in  1  sink consumes the held byte
- pa_in  in  8  Port A pin value
- pa_out  out  8  Port A drive value
- pa_oe  out  1  Port A drive enable; tristate at top level
- stbb  out  1  to PC4, active low
- ackb  out  1  to PC6, active low
- ibf  in  1  from PC5, active high, asynchronous
- obfb  in  1  from PC7, active low, asynchronous
- hs_err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- All outputs are registered except tx_ready.
- Reset values: stbb=1, ackb=1, pa_oe=0, pa_out=0, rx_valid=0, rx_data=0, hs_err=0, state=IDLE, grant_last=TX.
- Synchronisation: ibf and obfb each pass through a 2-flop synchronizer, giving ibf_s and obf_s (obf_s = !obfb synchronized). All decisions use these synchronized signals.
- tx_ready = (state==IDLE) && !ibf_s && !pick_ack.
- Eligibility terms:
  - ack_elig = obf_s && !rx_valid.
  - pick_ack = ack_elig && (grant_last==TX || !tx_valid).
  - When both requests are eligible they alternate. ACK goes first after reset.
- States:
  - IDLE:
    - If pick_ack: go to ACK_LO with ackb=0 and grant_last=ACK.
    - Else if tx_valid && tx_ready: latch tx_data into pa_out, set pa_oe=1, grant_last=TX, go to SETUP.
  - SETUP: hold for SETUP_CYC cycles, then stbb=0 and go to STB_LO.
  - STB_LO: hold for STB_WIDTH cycles, then stbb=1 and go to HOLD.
  - HOLD: hold for HOLD_CYC cycles, then pa_oe=0 and go to WAIT_IBF.
  - WAIT_IBF:
    - Wait for ibf_s=1, then go to IDLE. tx stays blocked until ibf_s=0, because the CPU must read the ppi first.
    - If HS_TIMEOUT cycles elapse first: pulse hs_err and go to IDLE.
  - ACK_LO:
    - Hold ackb=0 for ACK_WIDTH cycles. pa_oe stays 0 throughout, since the ppi drives Port A.
    - On the last low cycle: rx_data<=pa_in, rx_valid<=1, ackb<=1, go to WAIT_OBF.
  - WAIT_OBF:
    - Wait for obf_s=0, then go to IDLE. This prevents a double-ACK caused by synchronizer lag.
    - If HS_TIMEOUT cycles elapse first: pulse hs_err and go to IDLE.
- Timing from acceptance at edge T, with defaults:
  - pa_oe=1 at T+1.
  - stbb low during T+2..T+3.
  - stbb high from T+4.
  - pa_oe=0 from T+5.
- rx holding register:
  - rx_valid clears on rx_valid && rx_ready.
  - A simultaneous consume and new capture is impossible, since ACK requires !rx_valid.
- Invariant: pa_oe=1 and ackb=0 are never asserted together. stbb and ackb are never low together.
- A single counter, width clog2(max parameter)+1, is shared by all timed states. It reloads on every state entry.
- Reset mid-operation: next edge forces the reset values, releasing stbb/ackb high and pa_oe low. Any in-flight tx byte and any held rx byte are discarded.

Decomposition:
- Package ppi_pkg:
  - state enum (IDLE, SETUP, STB_LO, HOLD, WAIT_IBF, ACK_LO, WAIT_OBF);
  - grant enum (TX, ACK);
  - default timing constants;
  - PC bit indices (STB=4, IBF=5, ACK=6, OBF=7).
- Sub-module ppi_sync2: 2-flop synchronizer with reset value parameter. Instanced for ibf (reset 0) and obfb (reset 1).

Test Plan:
- Reset, then tx_valid=1, tx_data=8'hA5, with a model ppi raising ibf 2 cycles after stbb rises -> tx_ready pulse, pa_out=A5 with pa_oe for 4 cycles, stbb low exactly 2 cycles, no hs_err.
- Model drops obfb with pa_in=8'hAA -> ackb low 2 cycles, pa_oe=0 throughout, rx_valid=1 with rx_data=AA; model raises obfb -> IDLE.
- Both pending after reset (tx 8'h35, obfb low) -> ACK served first, then tx; with both pending again, TX is served before ACK.
- rx_ready=0 with rx_valid=1 and obfb low -> no ACK issued. rx_ready=1 -> next ACK begins within 2 cycles.
- ibf never rises after a strobe -> hs_err pulses at exactly 16 cycles in WAIT_IBF, then IDLE. ibf held high -> tx_ready stays 0.
- reset asserted during STB_LO and during ACK_LO -> next cycle stbb=1, ackb=1, pa_oe=0, rx_valid=0.
